// File: rtl/alu_iterative.sv
// alu_iterative: KGP-RISC execute stage (add/comp/and/xor/shifts) with registered result and carry/zero/sign/illegal flags.
// Latency: 1 cycle; shifts by n>=1 take n cycles, one bit per cycle, unless ALU_BARREL_SHIFT_EN selects a 1-cycle barrel shifter.
// Backpressure: start is accepted only while idle (busy low); requests made while busy are dropped.
module alu_iterative #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        opcode,
  input  logic [3:0]        fcode,
  input  logic [DATA_W-1:0] ALU_inp1,
  input  logic [DATA_W-1:0] ALU_inp2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              sign,
  output logic              illegal
);
`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE, EXEC} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;
`endif
  typedef enum logic [2:0] {K_ADD, K_COMP, K_AND, K_XOR, K_SHL, K_SHR, K_SRA, K_ILL} kind_t;

  state_t             state, state_nxt;
  kind_t              kind_dec, kind_q;
  logic [DATA_W-1:0]  a_q, b_q, ex_res, fin_res;
  logic [SHAMT_W-1:0] cnt_q;
  logic [DATA_W:0]    sum;
  logic               ex_carry, fin_carry, accept, finish;

  assign busy = (state != IDLE);

  always_comb begin
    kind_dec = K_ILL;
    if (opcode == 3'd0) begin
      case (fcode)
        4'd0:       kind_dec = K_ADD;
        4'd1:       kind_dec = K_COMP;
        4'd2:       kind_dec = K_AND;
        4'd3:       kind_dec = K_XOR;
        4'd4, 4'd6: kind_dec = K_SHL;
        4'd5, 4'd7: kind_dec = K_SHR;
        4'd8, 4'd9: kind_dec = K_SRA;
        default:    kind_dec = K_ILL;
      endcase
    end else if (opcode == 3'd1) begin
      case (fcode)
        4'd0:    kind_dec = K_ADD;
        4'd1:    kind_dec = K_COMP;
        default: kind_dec = K_ILL;
      endcase
    end
  end

  always_comb begin
    ex_res   = '0;
    ex_carry = 1'b0;
    sum      = {1'b0, a_q} + {1'b0, b_q};
    case (kind_q)
      K_ADD:  {ex_carry, ex_res} = sum;
      K_COMP: ex_res = ~b_q + DATA_W'(1);
      K_AND:  ex_res = a_q & b_q;
      K_XOR:  ex_res = a_q ^ b_q;
`ifdef ALU_BARREL_SHIFT_EN
      // Extra bit beside the operand catches the last bit shifted out (stays 0 for n=0).
      K_SHL:  {ex_carry, ex_res} = {1'b0, a_q} << cnt_q;
      K_SHR:  {ex_res, ex_carry} = {a_q, 1'b0} >> cnt_q;
      K_SRA:  {ex_res, ex_carry} = $signed({a_q, 1'b0}) >>> cnt_q;
`else
      // Only shift-by-0 reaches EXEC in the iterative build.
      K_SHL, K_SHR, K_SRA: ex_res = a_q;
`endif
      default: ;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign fin_res   = ex_res;
  assign fin_carry = ex_carry;
`else
  logic [DATA_W-1:0] sh_val;
  logic              sh_out;

  always_comb begin
    sh_val = a_q;
    sh_out = 1'b0;
    case (kind_q)
      K_SHL:   {sh_out, sh_val} = {a_q, 1'b0};
      K_SHR:   {sh_val, sh_out} = {1'b0, a_q};
      K_SRA:   {sh_val, sh_out} = {a_q[DATA_W-1], a_q};
      default: ;
    endcase
  end

  assign fin_res   = (state == SHIFT) ? sh_val : ex_res;
  assign fin_carry = (state == SHIFT) ? sh_out : ex_carry;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept = 1'b1;
`ifdef ALU_BARREL_SHIFT_EN
        state_nxt = EXEC;
`else
        state_nxt = ((kind_dec inside {K_SHL, K_SHR, K_SRA}) && (ALU_inp2[SHAMT_W-1:0] != '0))
                    ? SHIFT : EXEC;
`endif
      end
      EXEC: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
`ifndef ALU_BARREL_SHIFT_EN
      SHIFT: if (cnt_q == SHAMT_W'(1)) begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      kind_q  <= K_ADD;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      sign    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        a_q    <= ALU_inp1;
        b_q    <= ALU_inp2;
        cnt_q  <= ALU_inp2[SHAMT_W-1:0];
        kind_q <= kind_dec;
      end
`ifndef ALU_BARREL_SHIFT_EN
      else if (state == SHIFT) begin
        a_q   <= sh_val;
        cnt_q <= cnt_q - SHAMT_W'(1);
      end
`endif
      if (finish) begin
        result  <= fin_res;
        carry   <= fin_carry;
        zero    <= (fin_res == '0);
        sign    <= fin_res[DATA_W-1];
        illegal <= (kind_q == K_ILL);
      end
    end
  end
endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: vector table plus hand sequences for busy-drop and mid-shift reset.
module tb_alu_iterative;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, carry, zero, sign, illegal;
  logic [2:0]  opcode;
  logic [3:0]  fcode;
  logic [31:0] a_in, b_in, result;

  int errors = 0;
  int checks = 0;

  alu_iterative #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .fcode(fcode),
    .ALU_inp1(a_in), .ALU_inp2(b_in), .busy(busy), .done(done),
    .result(result), .carry(carry), .zero(zero), .sign(sign), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  fc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        ill;
    int          lat;
  } vec_t;

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%0d] %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves at #1 after edge k (the accepting edge).
  task automatic issue(input logic [2:0] op, input logic [3:0] fc, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; opcode = op; fcode = fc; a_in = a; b_in = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic measure(input int maxc, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    for (int j = 1; j <= maxc; j++) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      if (done) begin
        lat = j;
        break;
      end
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat, bn;
    issue(v.op, v.fc, v.a, v.b);
    measure(40, lat, bn);
    chk(idx, "latency", lat, v.lat);
    chk(idx, "busy_cycles", bn, v.lat);
    chk(idx, "busy_at_done", {31'b0, busy}, 32'd0);
    chk(idx, "result", result, v.res);
    chk(idx, "carry", {31'b0, carry}, {31'b0, v.c});
    chk(idx, "zero", {31'b0, zero}, {31'b0, (v.res == 32'd0)});
    chk(idx, "sign", {31'b0, sign}, {31'b0, v.res[31]});
    chk(idx, "illegal", {31'b0, illegal}, {31'b0, v.ill});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    int   dn, lat;
    vec_t v_add;

    vecs[0]  = '{3'd0, 4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
    vecs[1]  = '{3'd1, 4'd0, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 1'b1, 1'b0, 1};
    vecs[2]  = '{3'd0, 4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1};
    vecs[3]  = '{3'd0, 4'd8, 32'h80000010, 32'h00000004, 32'hF8000001, 1'b0, 1'b0, 4};
    vecs[4]  = '{3'd0, 4'd5, 32'h0000000F, 32'h00000003, 32'h00000001, 1'b1, 1'b0, 3};
    vecs[5]  = '{3'd0, 4'd2, 32'h000000F0, 32'h000000FF, 32'h000000F0, 1'b0, 1'b0, 1};
    vecs[6]  = '{3'd0, 4'd3, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'd0, 4'd6, 32'h80000001, 32'h00000020, 32'h80000001, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'd0, 4'd7, 32'h80000003, 32'hFFFFFFE1, 32'h40000001, 1'b1, 1'b0, 1};
    vecs[9]  = '{3'd0, 4'd9, 32'h7FFFFFFF, 32'h00000002, 32'h1FFFFFFF, 1'b1, 1'b0, 2};
    vecs[10] = '{3'd3, 4'd0, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[11] = '{3'd0, 4'd10, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[12] = '{3'd1, 4'd2, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1};
    vecs[13] = '{3'd0, 4'd2, 32'h000000F0, 32'h000000FF, 32'h000000F0, 1'b0, 1'b0, 1};
    vecs[14] = '{3'd1, 4'd1, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
    vecs[15] = '{3'd0, 4'd4, 32'hC0000000, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1};
    vecs[16] = '{3'd0, 4'd9, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1};

    rst = 1'b1; start = 1'b0; opcode = 3'd0; fcode = 4'd0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk(-1, "rst_busy", {31'b0, busy}, 32'd0);
    chk(-1, "rst_done", {31'b0, done}, 32'd0);
    chk(-1, "rst_result", result, 32'd0);
    chk(-1, "rst_flags", {28'b0, carry, zero, sign, illegal}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Consecutive vectors start in the done cycle, so each is a back-to-back request.
    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // 31-bit shift; an add pulsed at k+5 while busy must be dropped.
    @(posedge clk);
    #1;
    issue(3'd0, 4'd4, 32'h00000001, 32'd31);
    dn = 0; lat = 0;
    for (int j = 1; j <= 40; j++) begin
      if (j == 5) begin
        start = 1'b1; opcode = 3'd0; fcode = 4'd0; a_in = 32'd2; b_in = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        dn++;
        if (lat == 0) lat = j;
      end
    end
    chk(100, "shl31_latency", lat, 31);
    chk(100, "shl31_done_count", dn, 1);
    chk(100, "shl31_result", result, 32'h80000000);
    chk(100, "shl31_sign", {31'b0, sign}, 32'd1);
    chk(100, "shl31_carry", {31'b0, carry}, 32'd0);
    chk(100, "shl31_idle_after", {31'b0, busy}, 32'd0);

    // Reset at k+10 of a 31-bit shift abandons it without a done.
    issue(3'd0, 4'd4, 32'h00000001, 32'd31);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk(200, "midrst_busy", {31'b0, busy}, 32'd0);
    chk(200, "midrst_done", {31'b0, done}, 32'd0);
    chk(200, "midrst_result", result, 32'd0);
    chk(200, "midrst_flags", {28'b0, carry, zero, sign, illegal}, 32'd0);
    rst = 1'b0;
    dn = 0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (done || busy) dn++;
    end
    chk(200, "midrst_no_activity", dn, 0);

    v_add = '{3'd0, 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1};
    run_vec(201, v_add);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
Execute stage of the KGP-RISC datapath. It sits directly downstream of the ALU operand selector, which supplies ALU_inp1/ALU_inp2, and it consumes the same opcode/fcode fields. It performs arithmetic, logic and shift operations under a start/done handshake. Shifts run iteratively, one bit per cycle. It registers the result together with carry, zero and sign flags for writeback and branch logic.

Parameters:
DATA_W, 32, datapath width (result, operands).
SHAMT_W, 5, width of shift-amount field taken from ALU_inp2[SHAMT_W-1:0].

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle
opcode  input  3  instruction opcode (0 = R-type, 1 = immediate)
fcode  input  4  function code
ALU_inp1  input  DATA_W  operand A
ALU_inp2  input  DATA_W  operand B / shift amount
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result/flags valid from this cycle on
result  output  DATA_W  registered result, held until next completion
carry  output  1  carry flag
zero  output  1  result == 0
sign  output  1  result[DATA_W-1]
illegal  output  1  unsupported opcode/fcode on last completed op

Behaviour:
- Interface decision: one clock (clk); rst synchronous, active-high.
- Reset: state IDLE; busy, done, result, carry, zero, sign and illegal all 0. A reset mid-operation abandons it and produces no done.
- States:
  - IDLE: on start at edge k, latch A, B, opcode, fcode; cnt <= B[4:0].
    - Shift op with cnt != 0 -> SHIFT.
    - Otherwise -> EXEC.
  - EXEC: compute, register result/flags, done=1 -> IDLE.
  - SHIFT: each edge shifts the working register by 1 and decrements cnt. On the edge where cnt==1, register result/flags, done=1 -> IDLE.
- Latency: non-shift and shift-by-0 complete at edge k+1; shift by n (n>=1) completes at edge k+n.
- busy = (state != IDLE). done is high exactly one cycle. start is ignored while busy.
- Back-to-back: start in the cycle where done is high is accepted (state is IDLE).
- Ops, opcode=0:
  - fcode 0 add: A+B.
  - fcode 1 comp: ~B+1.
  - fcode 2 and; fcode 3 xor.
  - fcode 4/6 shll: logical left.
  - fcode 5/7 shrl: logical right.
  - fcode 8/9 shra: arithmetic right, sign-fill.
- Ops, opcode=1: fcode 0 addi = A+B; fcode 1 compi = ~B+1.
- Shift amount is always B[4:0]; upper bits of B are ignored.
- Flags:
  - carry: add/addi -> bit 32 of the 33-bit sum. Shift -> last bit shifted out (0 if n=0). All other ops -> 0.
  - zero and sign are computed from the final result.
  - Flags update only on completion.
- Illegal: any other opcode, or any other fcode, completes at k+1 with result=0, carry=0, zero=1, sign=0, illegal=1. illegal is cleared by the next legal completion.
- Arithmetic wraps modulo 2^DATA_W. No overflow flag.

Optional Feature:
- Macro: ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter in EXEC. All ops complete at edge k+1, the SHIFT state is not built, and carry = last bit out (0 if n=0).
- Undefined: iterative shifting as specified above.

Test Plan:
- opcode0 fcode0, A=0xFFFFFFFF, B=0x1, start at edge k -> done at k+1 only; result=0x00000000, carry=1, zero=1, sign=0, busy high one cycle.
- opcode1 fcode0, A=5, B=0xFFFFFFFD -> result=0x2, carry=1. Then back-to-back opcode0 fcode1, B=1 -> result=0xFFFFFFFF, sign=1, carry=0.
- opcode0 fcode8, A=0x80000010, B=4 -> busy 4 cycles, done at k+4, result=0xF8000001, carry=0. Then fcode5, A=0xF, B=3 -> result=0x1, carry=1 at k+3.
- opcode0 fcode4, A=1, B=31; second start (add) pulsed at k+5 -> single done at k+31, result=0x80000000, sign=1; second request dropped.
- Reset asserted at k+10 of a 31-bit shift -> next cycle all outputs 0, busy=0, no done. A subsequent add 2+3 -> result=5 at k'+1.
- opcode=3 fcode=0 -> done at k+1, illegal=1, result=0, zero=1. Next legal and 0xF0&0xFF -> result=0xF0, illegal=0.
